ram_rd_stream: RTL and testbench
================================

Name: ram_rd_stream

Overview:
- Reader end of the dual-port buffer RAM.
- After a writer fills the 256x8 RAM, this block reads back a burst of `len` words from `start_addr` through the RAM read port.
- RAM read port has 1-cycle synchronous latency.
- Output is a valid/ready stream with full backpressure, buffered by a 2-entry skid FIFO. No beat is lost or duplicated.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 8, RAM address width.
- DEPTH, 256, RAM depth; equals 2**ADDR_W.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle burst request; accepted only when busy=0.
- start_addr  in  ADDR_W  first RAM address of the burst.
- len  in  ADDR_W+1  burst length in words, 0..DEPTH.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the burst completes.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  RAM read data, valid the cycle after rd_en.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final beat of the burst.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, m_valid=0, m_last=0, m_data=0; FSM in IDLE; FIFO empty; all counters 0.
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ on start with len!=0: capture start_addr, capture clamped len (values >DEPTH clamp to DEPTH), clear issue and beat counters.
  - IDLE, start with len=0: no READ; done pulses next cycle; busy stays 0.
  - READ -> DRAIN when issued count == len.
  - DRAIN -> IDLE on the handshake of the m_last beat; done pulses the following cycle.
- start while busy=1 is ignored, with no side effects.
- Read issue rule: rd_en=1 in READ when issued<len and (fifo_cnt + pending - pop) < 2.
  - pending = rd_en registered from the previous cycle.
  - pop = m_valid & m_ready.
  - This gives full throughput with m_ready held high. The m_ready->rd_en combinational path is intended.
- rd_addr: start_addr for the first read, +1 per issued read, wraps modulo DEPTH (0xFF -> 0x00).
- rd_data is written into the FIFO in the cycle after rd_en, unconditionally. The credit rule guarantees no overflow.
- FIFO: 2 entries.
  - Head is presented as registered m_data/m_valid.
  - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
- m_last=1 exactly when the presented beat index == len-1.
- Latency: start at cycle 0 -> rd_en at cycle 1 -> rd_data at cycle 2 -> m_valid at cycle 3.
- Sustained rate: 1 beat/cycle while m_ready=1.
- Simultaneous FIFO push and pop with fifo_cnt=2: allowed; count is unchanged.
- Reset asserted mid-burst: immediate return to reset values; in-flight RAM data is discarded.

Optional Feature:
- Macro RD_STREAM_CNT_EN.
- Defined: adds output burst_cnt [15:0], reset 0.
  - Increments on each done pulse, including len=0 bursts.
  - Saturates at 16'hFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ram_pkg:
  - DATA_W and ADDR_W/DEPTH defaults.
  - FSM state encoding localparams (IDLE=2'd0, READ=2'd1, DRAIN=2'd2).
- One natural sub-module: skid_fifo2 (2-entry registered FIFO with count output). Reusable for the write side.

Test Plan:
- Full burst: RAM preloaded mem[i]=i; start_addr=0, len=256, m_ready=1.
  - 256 beats with data 0..255 on consecutive cycles.
  - m_last on data 255.
  - First m_valid at cycle 3.
  - done exactly 1 cycle after the last beat.
- Wrap: start_addr=0xFE, len=4.
  - rd_addr sequence FE, FF, 00, 01.
  - Data FE, FF, 00, 01.
- Backpressure: len=16, m_ready toggled by random 50% pattern.
  - All 16 beats in order; no drops or duplicates.
  - m_data stable while stalled; fifo_cnt never exceeds 2.
- Edge lengths:
  - len=0 -> done next cycle, m_valid never asserts.
  - len=1 -> single beat with m_last=1.
  - len=300 -> clamped to 256 beats.
- Start while busy: second start pulse mid-burst with a different address is ignored; the first burst completes unchanged.
- Reset mid-burst: rst asserted at beat 5 of 16.
  - All outputs return to reset values the same cycle.
  - After release, a new burst of len=3 streams correctly.
  - With RD_STREAM_CNT_EN defined: burst_cnt resets to 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared widths and FSM encoding for the buffer RAM reader/writer pair.
// No logic; types and defaults only.
// Not applicable (no handshake).
package ram_pkg;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;
endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO whose head is held in a register and presented directly as dout/vld.
// Latency: push visible on dout/vld the cycle after the push.
// Backpressure: head holds while pop=0; caller must never push into a full FIFO without popping.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         vld,
    output logic [1:0]   cnt
);
    logic [W-1:0] slot1;
    logic         do_pop;

    assign vld    = (cnt != 2'd0);
    assign do_pop = pop & vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) dout  <= din;
                    else             slot1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    dout <= slot1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the second slot shifts up when both are occupied.
                    if (cnt == 2'd2) begin
                        dout  <= slot1;
                        slot1 <= din;
                    end else begin
                        dout <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ram_rd_stream.sv
// Reads a burst of len words from the buffer RAM and streams them out; RD_STREAM_CNT_EN adds burst_cnt.
// Latency: start -> rd_en +1 cycle -> m_valid +3 cycles; 1 beat/cycle sustained.
// Backpressure: credit-gated reads into a 2-entry skid FIFO, so stalls never drop or repeat a beat.
module ram_rd_stream
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
`ifdef RD_STREAM_CNT_EN
    output logic [15:0]       burst_cnt,
`endif
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    rd_state_t         state, state_nxt;
    logic [ADDR_W:0]   len_q, issued, beat;
    logic [ADDR_W-1:0] addr_q;
    logic              pend, pop, last_hs, go;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;

    assign busy    = (state != IDLE);
    assign rd_addr = addr_q;
    assign pop     = m_valid & m_ready;
    assign go      = (state == IDLE) && start && (len != '0);
    // Occupancy once this cycle settles: stored + data returning from RAM - beat leaving.
    assign occ     = {1'b0, fifo_cnt} + {2'b00, pend} - {2'b00, pop};
    assign m_last  = m_valid && (beat == len_q - ONE);
    assign last_hs = pop & m_last;

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE:  if (go) state_nxt = READ;
            READ: begin
                if (issued == len_q) state_nxt = DRAIN;
                else if (occ < 3'd2) rd_en = 1'b1;
            end
            DRAIN: if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= 1'b0;
            done   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            issued <= '0;
            beat   <= '0;
        end else begin
            state <= state_nxt;
            pend  <= rd_en;
            done  <= ((state == IDLE) && start && (len == '0)) || ((state == DRAIN) && last_hs);
            if (go) begin
                addr_q <= start_addr;
                len_q  <= (len > LEN_MAX) ? LEN_MAX : len;
                issued <= '0;
                beat   <= '0;
            end else begin
                if (rd_en) begin
                    addr_q <= addr_q + 1'b1;
                    issued <= issued + ONE;
                end
                if (pop) beat <= beat + ONE;
            end
        end
    end

    skid_fifo2 #(.W(DATA_W)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (pend),
        .din  (rd_data),
        .pop  (pop),
        .dout (m_data),
        .vld  (m_valid),
        .cnt  (fifo_cnt)
    );

`ifdef RD_STREAM_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  burst_cnt <= 16'd0;
        else if (done && burst_cnt != 16'hFFFF)   burst_cnt <= burst_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed bench for ram_rd_stream with a 1-cycle synchronous RAM model (mem[i]=i).
module tb_ram_rd_stream;
    localparam int BUDGET = 1500;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic [7:0] start_addr = 8'd0;
    logic [8:0] len = 9'd0;
    logic       busy, done, rd_en, m_valid, m_last;
    logic       m_ready = 1'b0;
    logic [7:0] rd_addr, rd_data, m_data;
`ifdef RD_STREAM_CNT_EN
    logic [15:0] burst_cnt;
    int          exp_bursts = 0;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [256];
    logic [31:0] rdy_pat = 32'hB4E1_6A3D;

    logic [7:0] got_data[$];
    logic [7:0] got_addr[$];
    logic       got_last[$];
    int first_vld, done_cyc, last_hs, done_cnt, busy_cyc, stall_err, occ_err;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    ram_rd_stream u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
`ifdef RD_STREAM_CNT_EN
        .burst_cnt  (burst_cnt),
`endif
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    function automatic int data_bad(input logic [7:0] base);
        int bad = 0;
        for (int k = 0; k < got_data.size(); k++)
            if (got_data[k] !== base + 8'(k)) bad++;
        return bad;
    endfunction

    function automatic int last_bad(input int n);
        int bad = 0;
        for (int k = 0; k < got_last.size(); k++)
            if (got_last[k] !== (k == n - 1)) bad++;
        return bad;
    endfunction

    // Cycle 0 is the cycle in which start is driven; samples taken 1 ns after each falling edge.
    task automatic run_burst(input logic [7:0] a, input logic [8:0] n, input int mode, input int restart_cyc);
        logic       stalled;
        logic [7:0] held;
        got_data.delete(); got_addr.delete(); got_last.delete();
        first_vld = -1; done_cyc = -1; last_hs = -1;
        done_cnt = 0; busy_cyc = 0; stall_err = 0; occ_err = 0;
        stalled = 1'b0; held = 8'd0;
        @(negedge clk);
        start = 1'b1; start_addr = a; len = n; m_ready = 1'b1;
        #1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            start = (c == restart_cyc);
            if (c == restart_cyc) begin
                start_addr = a + 8'h40;
                len = 9'd5;
            end
            m_ready = (mode == 0) ? 1'b1 : rdy_pat[c % 32];
            #1;
            if (rd_en) got_addr.push_back(rd_addr);
            if (m_valid && first_vld < 0) first_vld = c;
            if (stalled && (!m_valid || m_data !== held)) stall_err++;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                last_hs = c;
            end
            stalled = m_valid && !m_ready;
            held = m_data;
            if (u_dut.u_fifo.cnt > 2'd2) occ_err++;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0;
`ifdef RD_STREAM_CNT_EN
        exp_bursts++;
`endif
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL burst_timeout: no done within %0d cycles (addr %0h len %0d)", BUDGET, a, n); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b expected 0", rd_en); end
        checks++; if (rd_addr !== 8'h00) begin errors++; $display("FAIL rst_rd_addr: got %0h expected 0", rd_addr); end
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL rst_valid_last: got %b%b expected 00", m_valid, m_last); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data: got %0h expected 0", m_data); end
`ifdef RD_STREAM_CNT_EN
        checks++; if (burst_cnt !== 16'd0) begin errors++; $display("FAIL rst_burst_cnt: got %0d expected 0", burst_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_burst;
        run_burst(8'h00, 9'd256, 0, 0);
        checks++; if (got_data.size() != 256) begin errors++; $display("FAIL full_beats: got %0d expected 256", got_data.size()); end
        checks++; if (data_bad(8'h00) != 0) begin errors++; $display("FAIL full_data: got %0d bad beats expected 0", data_bad(8'h00)); end
        checks++; if (last_bad(256) != 0) begin errors++; $display("FAIL full_last: got %0d bad flags expected 0", last_bad(256)); end
        checks++; if (first_vld != 3) begin errors++; $display("FAIL full_first_valid: got cycle %0d expected 3", first_vld); end
        checks++; if (last_hs != 258) begin errors++; $display("FAIL full_last_cycle: got cycle %0d expected 258", last_hs); end
        checks++; if (done_cyc != 259 || done_cnt != 1) begin errors++; $display("FAIL full_done: got cycle %0d count %0d expected 259 1", done_cyc, done_cnt); end
        checks++; if (busy_cyc != 258) begin errors++; $display("FAIL full_busy: got %0d cycles expected 258", busy_cyc); end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_addr [4];
        exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        run_burst(8'hFE, 9'd4, 0, 0);
        checks++; if (got_addr.size() != 4) begin errors++; $display("FAIL wrap_reads: got %0d expected 4", got_addr.size()); end
        for (int k = 0; k < 4 && k < got_addr.size(); k++) begin
            checks++; if (got_addr[k] !== exp_addr[k]) begin errors++; $display("FAIL wrap_addr%0d: got %0h expected %0h", k, got_addr[k], exp_addr[k]); end
        end
        checks++; if (got_data.size() != 4 || data_bad(8'hFE) != 0) begin errors++; $display("FAIL wrap_data: got %0d beats %0d bad expected 4 0", got_data.size(), data_bad(8'hFE)); end
        checks++; if (last_bad(4) != 0 || done_cyc != last_hs + 1) begin errors++; $display("FAIL wrap_last_done: got last_bad %0d done %0d expected 0 %0d", last_bad(4), done_cyc, last_hs + 1); end
    endtask

    task automatic test_backpressure;
        run_burst(8'h40, 9'd16, 1, 0);
        checks++; if (got_data.size() != 16) begin errors++; $display("FAIL bp_beats: got %0d expected 16", got_data.size()); end
        checks++; if (data_bad(8'h40) != 0) begin errors++; $display("FAIL bp_data: got %0d bad beats expected 0", data_bad(8'h40)); end
        checks++; if (last_bad(16) != 0) begin errors++; $display("FAIL bp_last: got %0d bad flags expected 0", last_bad(16)); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
        checks++; if (occ_err != 0) begin errors++; $display("FAIL bp_occupancy: got %0d overfull cycles expected 0", occ_err); end
        checks++; if (done_cyc != last_hs + 1 || done_cnt != 1) begin errors++; $display("FAIL bp_done: got cycle %0d count %0d expected %0d 1", done_cyc, done_cnt, last_hs + 1); end
    endtask

    task automatic test_edge_lengths;
        run_burst(8'h10, 9'd0, 0, 0);
        checks++; if (done_cyc != 1 || done_cnt != 1) begin errors++; $display("FAIL len0_done: got cycle %0d count %0d expected 1 1", done_cyc, done_cnt); end
        checks++; if (first_vld != -1 || got_addr.size() != 0) begin errors++; $display("FAIL len0_quiet: got first_valid %0d reads %0d expected -1 0", first_vld, got_addr.size()); end
        checks++; if (busy_cyc != 0) begin errors++; $display("FAIL len0_busy: got %0d cycles expected 0", busy_cyc); end
        run_burst(8'h77, 9'd1, 0, 0);
        checks++; if (got_data.size() != 1 || data_bad(8'h77) != 0) begin errors++; $display("FAIL len1_data: got %0d beats %0d bad expected 1 0", got_data.size(), data_bad(8'h77)); end
        checks++; if (last_bad(1) != 0) begin errors++; $display("FAIL len1_last: got %0d bad flags expected 0", last_bad(1)); end
        checks++; if (first_vld != 3 || done_cyc != 4) begin errors++; $display("FAIL len1_timing: got valid %0d done %0d expected 3 4", first_vld, done_cyc); end
        run_burst(8'h10, 9'd300, 0, 0);
        checks++; if (got_data.size() != 256) begin errors++; $display("FAIL len300_beats: got %0d expected 256", got_data.size()); end
        checks++; if (data_bad(8'h10) != 0 || last_bad(256) != 0) begin errors++; $display("FAIL len300_data: got %0d bad data %0d bad last expected 0 0", data_bad(8'h10), last_bad(256)); end
        checks++; if (done_cyc != 259) begin errors++; $display("FAIL len300_done: got cycle %0d expected 259", done_cyc); end
`ifdef RD_STREAM_CNT_EN
        checks++; if (burst_cnt !== 16'(exp_bursts)) begin errors++; $display("FAIL burst_cnt: got %0d expected %0d", burst_cnt, exp_bursts); end
`endif
    endtask

    task automatic test_start_while_busy;
        run_burst(8'h30, 9'd8, 0, 4);
        checks++; if (got_data.size() != 8 || data_bad(8'h30) != 0) begin errors++; $display("FAIL busy_data: got %0d beats %0d bad expected 8 0", got_data.size(), data_bad(8'h30)); end
        checks++; if (got_addr.size() != 8 || got_addr[got_addr.size()-1] !== 8'h37) begin errors++; $display("FAIL busy_reads: got %0d reads expected 8 ending 37", got_addr.size()); end
        checks++; if (done_cyc != 11 || done_cnt != 1) begin errors++; $display("FAIL busy_done: got cycle %0d count %0d expected 11 1", done_cyc, done_cnt); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; start_addr = 8'h20; len = 9'd16; m_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h25) begin errors++; $display("FAIL mid_beat5: got valid %b data %0h expected 1 25", m_valid, m_data); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL mid_ctrl: got busy %b done %b rd_en %b expected 000", busy, done, rd_en); end
        checks++; if (rd_addr !== 8'h00 || m_data !== 8'h00) begin errors++; $display("FAIL mid_addr_data: got %0h %0h expected 0 0", rd_addr, m_data); end
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL mid_stream: got valid %b last %b expected 0 0", m_valid, m_last); end
`ifdef RD_STREAM_CNT_EN
        checks++; if (burst_cnt !== 16'd0) begin errors++; $display("FAIL mid_burst_cnt: got %0d expected 0", burst_cnt); end
        exp_bursts = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_burst(8'hC8, 9'd3, 0, 0);
        checks++; if (got_data.size() != 3 || data_bad(8'hC8) != 0) begin errors++; $display("FAIL post_rst_data: got %0d beats %0d bad expected 3 0", got_data.size(), data_bad(8'hC8)); end
        checks++; if (last_bad(3) != 0 || first_vld != 3 || done_cyc != 6) begin errors++; $display("FAIL post_rst_timing: got last_bad %0d valid %0d done %0d expected 0 3 6", last_bad(3), first_vld, done_cyc); end
`ifdef RD_STREAM_CNT_EN
        checks++; if (burst_cnt !== 16'd1) begin errors++; $display("FAIL post_rst_burst_cnt: got %0d expected 1", burst_cnt); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        test_reset();
        test_full_burst();
        test_wrap();
        test_backpressure();
        test_edge_lengths();
        test_start_while_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
